// File: rtl/pc_fetch_stage.sv
// Fetch-path program counter: holds the current PC, offers it to decode over
// valid/ready, takes branch/jump redirects and counts them for debug.
module pc_fetch_stage #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0000_0000,
    parameter int unsigned          STEP     = 4,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                redirect,
    input  logic [WIDTH-1:0]    redirect_pc,
    input  logic                pc_ready,
    output logic                pc_valid,
    output logic [WIDTH-1:0]    pc_out,
    output logic [WIDTH-1:0]    pc_plus_step,
    output logic                misalign,
    output logic [CNT_W-1:0]    redirect_cnt
);

    // state | meaning
    // BOOT  | out of reset, nothing offered yet; first enabled edge moves to RUN
    // RUN   | pc_out is a live fetch address offered to decode
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT state;
    logic  validQ;
    logic  cntFull;

    assign pc_valid     = validQ & en;
    assign pc_plus_step = pc_out + WIDTH'(STEP);
    assign misalign     = validQ & en & (pc_out[1:0] != 2'b00);
    assign cntFull      = &redirect_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            validQ       <= 1'b0;
            pc_out       <= RESET_PC;
            redirect_cnt <= '0;
        end else if (en) begin
            case (state)
                BOOT: begin
                    state  <= RUN;
                    validQ <= 1'b1;
                    if (redirect) begin
                        pc_out <= redirect_pc;
                        if (!cntFull) redirect_cnt <= redirect_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A redirect wins over a transfer; decode still takes the old PC.
                    if (redirect) begin
                        pc_out <= redirect_pc;
                        if (!cntFull) redirect_cnt <= redirect_cnt + 1'b1;
                    end else if (pc_ready) begin
                        pc_out <= pc_plus_step;
                    end
                end
                default: begin
                    state  <= BOOT;
                    validQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a vector table for the main sequence plus
// hand-written reset, boot-redirect and counter-saturation sequences.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_ready;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_step;
    logic        misalign;
    logic [15:0] redirect_cnt;

    // Small-counter instance so saturation is reachable in a few cycles.
    logic        sEn;
    logic        sRedirect;
    logic [31:0] sRedirectPc;
    logic        sReady;
    logic        sValid;
    logic [31:0] sPc;
    logic [31:0] sPlus;
    logic        sMis;
    logic [2:0]  sCnt;

    int passCnt  = 0;
    int totalCnt = 0;

    pc_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc_ready(pc_ready), .pc_valid(pc_valid),
        .pc_out(pc_out), .pc_plus_step(pc_plus_step), .misalign(misalign),
        .redirect_cnt(redirect_cnt)
    );

    pc_fetch_stage #(.RESET_PC(32'h0000_1000), .CNT_W(3)) dutSmall (
        .clk(clk), .rst_n(rst_n), .en(sEn), .redirect(sRedirect),
        .redirect_pc(sRedirectPc), .pc_ready(sReady), .pc_valid(sValid),
        .pc_out(sPc), .pc_plus_step(sPlus), .misalign(sMis),
        .redirect_cnt(sCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic        expValid;
        logic [31:0] expPc;
        logic        expMis;
        logic [15:0] expCnt;
    } vecT;

    vecT vecs[$];

    task automatic addV(input logic e, input logic r, input logic [31:0] rp, input logic rd,
                        input logic ev, input logic [31:0] ep, input logic em, input logic [15:0] ec);
        vecT v;
        v.en = e; v.red = r; v.rpc = rp; v.rdy = rd;
        v.expValid = ev; v.expPc = ep; v.expMis = em; v.expCnt = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic e, input logic r, input logic [31:0] rp, input logic rd);
        en = e; redirect = r; redirect_pc = rp; pc_ready = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        sEn = 1'b0; sRedirect = 1'b0; sRedirectPc = 32'h0; sReady = 1'b0;

        //  en red rpc           rdy | valid pc           mis cnt
        addV(1, 0, 32'h0,        1,    0, 32'h0000_0000, 0, 16'd0);
        addV(1, 0, 32'h0,        1,    1, 32'h0000_0000, 0, 16'd0);
        addV(1, 0, 32'h0,        1,    1, 32'h0000_0004, 0, 16'd0);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0008, 0, 16'd0);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0008, 0, 16'd0);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0008, 0, 16'd0);
        addV(1, 0, 32'h0,        1,    1, 32'h0000_0008, 0, 16'd0);
        addV(1, 0, 32'h0,        1,    1, 32'h0000_000C, 0, 16'd0);
        addV(1, 1, 32'h100,      1,    1, 32'h0000_0010, 0, 16'd0);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0100, 0, 16'd1);
        addV(1, 1, 32'h180,      0,    1, 32'h0000_0100, 0, 16'd1);
        addV(1, 1, 32'h102,      1,    1, 32'h0000_0180, 0, 16'd2);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0102, 1, 16'd3);
        addV(1, 1, 32'h200,      0,    1, 32'h0000_0102, 1, 16'd3);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0200, 0, 16'd4);
        addV(1, 1, 32'hFFFF_FFFC,0,    1, 32'h0000_0200, 0, 16'd4);
        addV(1, 0, 32'h0,        1,    1, 32'hFFFF_FFFC, 0, 16'd5);
        addV(0, 1, 32'h300,      1,    0, 32'h0000_0000, 0, 16'd5);
        addV(0, 1, 32'h300,      1,    0, 32'h0000_0000, 0, 16'd5);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0000, 0, 16'd5);
        addV(1, 1, 32'h1,        0,    1, 32'h0000_0000, 0, 16'd5);
        addV(0, 0, 32'h0,        0,    0, 32'h0000_0001, 0, 16'd6);
        addV(1, 0, 32'h0,        0,    1, 32'h0000_0001, 1, 16'd6);

        #2;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_cnt", {16'b0, redirect_cnt}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].red, vecs[i].rpc, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, pc_valid}, {31'b0, vecs[i].expValid});
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].expPc);
            chk($sformatf("v%0d_plus", i), pc_plus_step, vecs[i].expPc + 32'd4);
            chk($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].expMis});
            chk($sformatf("v%0d_cnt", i), {16'b0, redirect_cnt}, {16'b0, vecs[i].expCnt});
            @(negedge clk);
        end

        // Asynchronous reset mid-run, asserted away from any clock edge.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc_out, 32'h0);
        chk("async_valid", {31'b0, pc_valid}, 32'h0);
        chk("async_cnt", {16'b0, redirect_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_boot_valid", {31'b0, pc_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("release_first_valid", {31'b0, pc_valid}, 32'h1);
        chk("release_first_pc", pc_out, 32'h0);

        // BOOT held with en=0, then a redirect on the BOOT->RUN edge.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("boot_hold_valid", {31'b0, pc_valid}, 32'h0);
        chk("boot_hold_pc", pc_out, 32'h0);
        en = 1'b1;
        @(negedge clk);
        #1;
        chk("boot_redir_pc", pc_out, 32'h40);
        chk("boot_redir_valid", {31'b0, pc_valid}, 32'h1);
        chk("boot_redir_cnt", {16'b0, redirect_cnt}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Saturation of a 3-bit counter (all-ones = 7).
        sEn = 1'b1;
        @(negedge clk);
        #1;
        chk("sat_reset_pc", sPc, 32'h0000_1000);
        chk("sat_start_cnt", {29'b0, sCnt}, 32'h0);
        sRedirect = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            sRedirectPc = 32'h2000 + 32'(k) * 32'd4;
            @(negedge clk);
            #1;
            if (k == 6) chk("sat_cnt6", {29'b0, sCnt}, 32'd6);
            if (k == 7) chk("sat_cnt7", {29'b0, sCnt}, 32'd7);
        end
        chk("sat_cnt_hold", {29'b0, sCnt}, 32'd7);
        chk("sat_last_pc", sPc, 32'h2000 + 32'd36);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
